// File: rtl/bram_portb_arbiter.sv
// rtl/bram_portb_arbiter.sv - port-B arbiter between CPU and loader for the byte-enable BRAM
// Fixed CPU priority with bounded loader starvation and a loader lock mode for bursts.
module bram_portb_arbiter #(
    parameter int AW         = 9,
    parameter int STARVE_MAX = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,

    input  logic          i_c_req,
    input  logic          i_c_we,
    input  logic [1:0]    i_c_be,
    input  logic [AW:1]   i_c_addr,
    input  logic [15:0]   i_c_wdata,
    output logic          o_c_gnt,
    output logic          o_c_rvalid,
    output logic [15:0]   o_c_rdata,

    input  logic          i_l_req,
    input  logic          i_l_we,
    input  logic [1:0]    i_l_be,
    input  logic [AW:1]   i_l_addr,
    input  logic [15:0]   i_l_wdata,
    input  logic          i_l_lock,
    output logic          o_l_gnt,
    output logic          o_l_rvalid,
    output logic [15:0]   o_l_rdata,

    output logic          o_lock,

    output logic          o_b_en,
    output logic          o_b_we_h,
    output logic          o_b_we_l,
    output logic [AW:1]   o_b_addr,
    output logic [7:0]    o_b_din_h,
    output logic [7:0]    o_b_din_l,
    input  logic [7:0]    i_b_dout_h,
    input  logic [7:0]    i_b_dout_l
);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LDR  = 2'd2
    } owner_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      r_state;
    state_t      w_state_nxt;
    owner_t      r_owner;
    logic [3:0]  r_starve;
    logic [3:0]  w_starve_nxt;
    logic        r_c_rvalid;
    logic        r_l_rvalid;
    logic        w_c_gnt;
    logic        w_l_gnt;
    logic        w_starved;
    logic        w_c_rd;
    logic        w_l_rd;

    assign w_starved = (r_starve == STARVE_LIM);

    always_comb begin
        w_c_gnt      = 1'b0;
        w_l_gnt      = 1'b0;
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve;
        // Grants are suppressed while reset is asserted, even asynchronously.
        if (i_rst_n) begin
            case (r_state)
                ST_ARB: begin
                    if (i_c_req && !(w_starved && i_l_req)) begin
                        w_c_gnt = 1'b1;
                    end else if (i_l_req) begin
                        w_l_gnt = 1'b1;
                    end
                    if (w_l_gnt && i_l_lock) begin
                        w_state_nxt = ST_LOCK;
                    end
                    if (w_l_gnt || !i_l_req) begin
                        w_starve_nxt = 4'd0;
                    end else if (w_c_gnt && !w_starved) begin
                        w_starve_nxt = r_starve + 4'd1;
                    end
                end
                ST_LOCK: begin
                    // The lock-release cycle itself is still served as LOCK.
                    w_l_gnt = i_l_req;
                    if (!i_l_lock) begin
                        w_state_nxt = ST_ARB;
                    end
                end
                default: begin
                    w_state_nxt = ST_ARB;
                end
            endcase
        end
    end

    assign w_c_rd = w_c_gnt & ~i_c_we;
    assign w_l_rd = w_l_gnt & ~i_l_we;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_ARB;
            r_starve   <= 4'd0;
            r_c_rvalid <= 1'b0;
            r_l_rvalid <= 1'b0;
            r_owner    <= OWN_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_starve   <= w_starve_nxt;
            r_c_rvalid <= w_c_rd;
            r_l_rvalid <= w_l_rd;
            if (w_c_rd) begin
                r_owner <= OWN_CPU;
            end else if (w_l_rd) begin
                r_owner <= OWN_LDR;
            end
        end
    end

    assign o_c_gnt    = w_c_gnt;
    assign o_l_gnt    = w_l_gnt;
    assign o_c_rvalid = r_c_rvalid;
    assign o_l_rvalid = r_l_rvalid;
    assign o_lock     = (r_state == ST_LOCK);

    // Read data belongs to whichever requester issued the most recent read.
    assign o_c_rdata  = (r_owner == OWN_CPU) ? {i_b_dout_h, i_b_dout_l} : 16'h0000;
    assign o_l_rdata  = (r_owner == OWN_LDR) ? {i_b_dout_h, i_b_dout_l} : 16'h0000;

    assign o_b_en     = w_c_gnt | w_l_gnt;
    assign o_b_we_h   = (w_c_gnt & i_c_we & i_c_be[1]) | (w_l_gnt & i_l_we & i_l_be[1]);
    assign o_b_we_l   = (w_c_gnt & i_c_we & i_c_be[0]) | (w_l_gnt & i_l_we & i_l_be[0]);
    assign o_b_addr   = w_l_gnt ? i_l_addr : i_c_addr;
    assign o_b_din_h  = w_l_gnt ? i_l_wdata[15:8] : i_c_wdata[15:8];
    assign o_b_din_l  = w_l_gnt ? i_l_wdata[7:0]  : i_c_wdata[7:0];

endmodule

// File: tb/tb_bram_portb_arbiter.sv
// tb/tb_bram_portb_arbiter.sv - directed self-checking bench for bram_portb_arbiter
module tb_bram_portb_arbiter;

    localparam int AW = 9;

    logic          clk;
    logic          rst_n;
    logic          c_req, c_we, l_req, l_we, l_lock;
    logic [1:0]    c_be, l_be;
    logic [AW:1]   c_addr, l_addr;
    logic [15:0]   c_wdata, l_wdata;
    logic          c_gnt, c_rvalid, l_gnt, l_rvalid, lock;
    logic [15:0]   c_rdata, l_rdata;
    logic          b_en, b_we_h, b_we_l;
    logic [AW:1]   b_addr;
    logic [7:0]    b_din_h, b_din_l;
    logic [15:0]   b_dout;
    logic [15:0]   mem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_fail   = 0;

    bram_portb_arbiter #(.AW(AW), .STARVE_MAX(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_c_req(c_req), .i_c_we(c_we), .i_c_be(c_be), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
        .o_c_gnt(c_gnt), .o_c_rvalid(c_rvalid), .o_c_rdata(c_rdata),
        .i_l_req(l_req), .i_l_we(l_we), .i_l_be(l_be), .i_l_addr(l_addr), .i_l_wdata(l_wdata),
        .i_l_lock(l_lock),
        .o_l_gnt(l_gnt), .o_l_rvalid(l_rvalid), .o_l_rdata(l_rdata),
        .o_lock(lock),
        .o_b_en(b_en), .o_b_we_h(b_we_h), .o_b_we_l(b_we_l), .o_b_addr(b_addr),
        .o_b_din_h(b_din_h), .o_b_din_l(b_din_l),
        .i_b_dout_h(b_dout[15:8]), .i_b_dout_l(b_dout[7:0])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural BRAM: read-first, 1-cycle registered read; preloaded while reset is low.
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[3] <= 16'hFFFF;
            mem[5] <= 16'hA55A;
        end else if (b_en) begin
            b_dout <= mem[b_addr];
            if (b_we_h) mem[b_addr][15:8] <= b_din_h;
            if (b_we_l) mem[b_addr][7:0]  <= b_din_l;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        c_req = 0; c_we = 0; c_be = 2'b11; c_addr = '0; c_wdata = '0;
        l_req = 0; l_we = 0; l_be = 2'b11; l_addr = '0; l_wdata = '0; l_lock = 0;
    endtask

    task automatic test_reset;
        idle();
        rst_n = 0; c_req = 1; l_req = 1;
        #3;
        n_checks++; if (c_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_c_gnt: got %b want 0", c_gnt); end
        n_checks++; if (l_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_l_gnt: got %b want 0", l_gnt); end
        n_checks++; if (b_en !== 1'b0) begin n_fail++; $display("FAIL rst_b_en: got %b want 0", b_en); end
        #9;
        n_checks++; if (lock !== 1'b0) begin n_fail++; $display("FAIL rst_lock: got %b want 0", lock); end
        n_checks++; if ({c_rvalid, l_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid: got %b want 00", {c_rvalid, l_rvalid}); end
        #10;
        idle();
        rst_n = 1;
    endtask

    task automatic test_cpu_read;
        tick();
        c_req = 1; c_we = 0; c_addr = 5;
        #1;
        n_checks++; if (c_gnt !== 1'b1) begin n_fail++; $display("FAIL rd_c_gnt: got %b want 1", c_gnt); end
        n_checks++; if (l_gnt !== 1'b0) begin n_fail++; $display("FAIL rd_l_gnt: got %b want 0", l_gnt); end
        n_checks++; if (b_en !== 1'b1 || b_addr !== 9'd5 || {b_we_h, b_we_l} !== 2'b00) begin
            n_fail++; $display("FAIL rd_bram_drive: got en=%b addr=%h we=%b%b want en=1 addr=005 we=00", b_en, b_addr, b_we_h, b_we_l); end
        tick();
        c_req = 0;
        n_checks++; if (c_rvalid !== 1'b1) begin n_fail++; $display("FAIL rd_c_rvalid: got %b want 1", c_rvalid); end
        n_checks++; if (c_rdata !== 16'hA55A) begin n_fail++; $display("FAIL rd_c_rdata: got %h want a55a", c_rdata); end
        n_checks++; if (l_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_l_rvalid: got %b want 0", l_rvalid); end
        tick();
        n_checks++; if (c_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_c_rvalid_pulse: got %b want 0", c_rvalid); end
    endtask

    task automatic test_write_be;
        tick();
        c_req = 1; c_we = 1; c_be = 2'b10; c_addr = 3; c_wdata = 16'h1234;
        #1;
        n_checks++; if ({b_we_h, b_we_l} !== 2'b10) begin n_fail++; $display("FAIL wr_be10_we: got %b%b want 10", b_we_h, b_we_l); end
        n_checks++; if (b_din_h !== 8'h12 || b_addr !== 9'd3) begin n_fail++; $display("FAIL wr_be10_data: got din_h=%h addr=%h want 12/003", b_din_h, b_addr); end
        tick();
        c_be = 2'b00; c_wdata = 16'h0000;
        n_checks++; if (c_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rvalid: got %b want 0", c_rvalid); end
        #1;
        n_checks++; if (c_gnt !== 1'b1 || {b_we_h, b_we_l} !== 2'b00) begin n_fail++; $display("FAIL wr_be00: got gnt=%b we=%b%b want 1/00", c_gnt, b_we_h, b_we_l); end
        tick();
        c_we = 0; c_be = 2'b00;
        n_checks++; if (c_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_be00_no_rvalid: got %b want 0", c_rvalid); end
        tick();
        idle();
        n_checks++; if (c_rvalid !== 1'b1 || c_rdata !== 16'h12FF) begin n_fail++; $display("FAIL wr_readback: got v=%b d=%h want 1/12ff", c_rvalid, c_rdata); end
    endtask

    task automatic test_starvation;
        logic exp_l;
        tick();
        c_req = 1; c_we = 0; c_addr = 3;
        l_req = 1; l_we = 0; l_addr = 5;
        for (int i = 0; i < 10; i++) begin
            exp_l = (i % 5 == 4);
            #1;
            n_checks++; if ({c_gnt, l_gnt} !== {~exp_l, exp_l}) begin n_fail++; $display("FAIL starve_gnt[%0d]: got c=%b l=%b want c=%b l=%b", i, c_gnt, l_gnt, ~exp_l, exp_l); end
            tick();
            n_checks++; if ({c_rvalid, l_rvalid} !== {~exp_l, exp_l}) begin n_fail++; $display("FAIL starve_rvalid[%0d]: got c=%b l=%b want c=%b l=%b", i, c_rvalid, l_rvalid, ~exp_l, exp_l); end
            n_checks++; if ((exp_l ? l_rdata : c_rdata) !== (exp_l ? 16'hA55A : 16'h12FF)) begin
                n_fail++; $display("FAIL starve_rdata[%0d]: got c=%h l=%h", i, c_rdata, l_rdata); end
        end
        idle();
    endtask

    task automatic test_pipeline;
        tick();
        c_req = 1; c_we = 0; c_addr = 5;
        #1;
        n_checks++; if (c_gnt !== 1'b1) begin n_fail++; $display("FAIL pipe_c_gnt: got %b want 1", c_gnt); end
        tick();
        c_req = 0; l_req = 1; l_we = 0; l_addr = 3;
        #1;
        n_checks++; if (l_gnt !== 1'b1) begin n_fail++; $display("FAIL pipe_l_gnt: got %b want 1", l_gnt); end
        n_checks++; if (c_rvalid !== 1'b1 || c_rdata !== 16'hA55A || l_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL pipe_n1: got cv=%b cd=%h lv=%b want 1/a55a/0", c_rvalid, c_rdata, l_rvalid); end
        tick();
        idle();
        n_checks++; if (l_rvalid !== 1'b1 || l_rdata !== 16'h12FF || c_rvalid !== 1'b0 || c_rdata !== 16'h0000) begin
            n_fail++; $display("FAIL pipe_n2: got lv=%b ld=%h cv=%b cd=%h want 1/12ff/0/0000", l_rvalid, l_rdata, c_rvalid, c_rdata); end
    endtask

    task automatic test_lock;
        tick();
        l_req = 1; l_we = 1; l_be = 2'b11; l_lock = 1; l_addr = 20; l_wdata = 16'hC0DE;
        #1;
        n_checks++; if (l_gnt !== 1'b1 || lock !== 1'b0) begin n_fail++; $display("FAIL lock_c0: got gnt=%b lock=%b want 1/0", l_gnt, lock); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            c_req = 1; c_we = 0; c_addr = 3;
            l_addr = 9'(20 + k); l_wdata = 16'hC0DE + 16'(k);
            n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL lock_state[%0d]: got %b want 1", k, lock); end
            #1;
            n_checks++; if (c_gnt !== 1'b0 || l_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_gnt[%0d]: got c=%b l=%b want 0/1", k, c_gnt, l_gnt); end
            n_checks++; if (b_addr !== 9'(20 + k) || {b_din_h, b_din_l} !== 16'hC0DE + 16'(k) || {b_we_h, b_we_l} !== 2'b11) begin
                n_fail++; $display("FAIL lock_drive[%0d]: got addr=%h din=%h%h we=%b%b", k, b_addr, b_din_h, b_din_l, b_we_h, b_we_l); end
        end
        tick();
        l_lock = 0; l_addr = 27; l_wdata = 16'hBEEF;
        n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL lock_release_state: got %b want 1", lock); end
        #1;
        n_checks++; if (c_gnt !== 1'b0 || l_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_release_gnt: got c=%b l=%b want 0/1", c_gnt, l_gnt); end
        tick();
        l_req = 0; l_we = 0; c_addr = 22;
        n_checks++; if (lock !== 1'b0) begin n_fail++; $display("FAIL lock_exit: got %b want 0", lock); end
        #1;
        n_checks++; if (c_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_cpu_after: got %b want 1", c_gnt); end
        tick();
        idle();
        n_checks++; if (c_rvalid !== 1'b1 || c_rdata !== 16'hC0E0) begin n_fail++; $display("FAIL lock_readback: got v=%b d=%h want 1/c0e0", c_rvalid, c_rdata); end
    endtask

    task automatic test_reset_mid_lock;
        tick();
        l_req = 1; l_we = 0; l_addr = 5; l_lock = 1;
        #1;
        n_checks++; if (l_gnt !== 1'b1) begin n_fail++; $display("FAIL rml_l_gnt: got %b want 1", l_gnt); end
        tick();
        l_addr = 3; c_req = 1; c_we = 0; c_addr = 5;
        #1;
        n_checks++; if (lock !== 1'b1 || l_gnt !== 1'b1 || l_rvalid !== 1'b1) begin
            n_fail++; $display("FAIL rml_pre: got lock=%b gnt=%b rv=%b want 1/1/1", lock, l_gnt, l_rvalid); end
        #1;
        rst_n = 0;
        #1;
        n_checks++; if (lock !== 1'b0 || {c_rvalid, l_rvalid} !== 2'b00) begin
            n_fail++; $display("FAIL rml_async: got lock=%b rv=%b%b want 0/00", lock, c_rvalid, l_rvalid); end
        n_checks++; if ({c_gnt, l_gnt, b_en} !== 3'b000) begin n_fail++; $display("FAIL rml_no_gnt: got %b want 000", {c_gnt, l_gnt, b_en}); end
        tick();
        n_checks++; if ({c_gnt, l_gnt, lock} !== 3'b000) begin n_fail++; $display("FAIL rml_held: got %b want 000", {c_gnt, l_gnt, lock}); end
        #1;
        rst_n = 1;
        #1;
        n_checks++; if ({c_rvalid, l_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rml_release_rv: got %b want 00", {c_rvalid, l_rvalid}); end
        n_checks++; if (c_gnt !== 1'b1 || l_gnt !== 1'b0) begin n_fail++; $display("FAIL rml_cpu_wins: got c=%b l=%b want 1/0", c_gnt, l_gnt); end
        tick();
        idle();
        n_checks++; if (l_rvalid !== 1'b0 || lock !== 1'b0) begin n_fail++; $display("FAIL rml_after: got lv=%b lock=%b want 0/0", l_rvalid, lock); end
        n_checks++; if (c_rvalid !== 1'b1 || c_rdata !== 16'hA55A) begin n_fail++; $display("FAIL rml_cpu_read: got v=%b d=%h want 1/a55a", c_rvalid, c_rdata); end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_write_be();
        test_starvation();
        test_pipeline();
        test_lock();
        test_reset_mid_lock();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_portb_arbiter.md
Name: bram_portb_arbiter

Overview:
- Shares the single data port (port B) of the 1 KB byte-enable BRAM between two requesters: the CPU load/store unit and the memory loader/debug engine.
- Fixed CPU priority, bounded loader starvation, and a loader lock mode for uninterrupted bursts.
- Grants in the same cycle as the request. Returns read data one cycle after the grant, matching the BRAM's 1-cycle registered read.
- Sits between the core/loader and the BRAM port-B pins.

Parameters:
- AW, 9: word-address width; addresses are [AW:1].
- STARVE_MAX, 4: consecutive CPU grants allowed while the loader waits; the next contended cycle goes to the loader. Range 1..15.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_c_req  in  1  CPU access request, single-cycle per access.
- i_c_we  in  1  CPU write (1) / read (0).
- i_c_be  in  2  CPU byte enables, [1]=high byte, [0]=low byte.
- i_c_addr  in  AW  CPU word address [AW:1].
- i_c_wdata  in  16  CPU write data.
- o_c_gnt  out  1  CPU access issued this cycle.
- o_c_rvalid  out  1  CPU read data valid.
- o_c_rdata  out  16  CPU read data.
- i_l_req, i_l_we, i_l_be[1:0], i_l_addr[AW:1], i_l_wdata[15:0]  in  loader request fields; same meaning as the CPU fields.
- i_l_lock  in  1  loader requests exclusive ownership.
- o_l_gnt, o_l_rvalid, o_l_rdata[15:0]  out  loader response fields; same meaning as the CPU fields.
- o_lock  out  1  arbiter is in LOCK state.
- o_b_en  out  1  BRAM port-B enable.
- o_b_we_h, o_b_we_l  out  1 each  BRAM byte write enables.
- o_b_addr  out  AW  BRAM address.
- o_b_din_h, o_b_din_l  out  8 each  BRAM write data.
- i_b_dout_h, i_b_dout_l  in  8 each  BRAM read data, registered inside the BRAM.

Behaviour:
- Reset (async, i_rst_n=0): state=ARB; starve counter=0; o_c_rvalid=o_l_rvalid=0; owner register=none; o_lock=0.
  - During reset all grants and o_b_en are forced 0.
  - An in-flight read is dropped; no rvalid follows reset release.
- States:
  - ARB: CPU wins whenever i_c_req=1, unless starve_cnt==STARVE_MAX, in which case the loader wins if i_l_req=1.
  - LOCK: only the loader may be granted; o_c_gnt=0 even when i_c_req=1.
- ARB->LOCK: at the edge where o_l_gnt=1 and i_l_lock=1.
- LOCK->ARB: at the edge where i_l_lock=0. The cycle with i_l_lock=0 is still arbitrated as LOCK.
- Grants are combinational from requests and registered state. At most one grant per cycle; o_c_gnt & o_l_gnt never both 1.
- BRAM drive:
  - o_b_en = o_c_gnt | o_l_gnt.
  - Address, data and byte enables are muxed from the granted requester.
  - o_b_we_h = gnt & we & be[1]; o_b_we_l = gnt & we & be[0].
  - When nothing is granted: o_b_en=0, we=0; address/data are don't-care but held at the CPU fields.
- Write with be=00: granted, no byte written, no rvalid.
- Read with be=00: full 16-bit read; byte enables are ignored on reads.
- Read latency:
  - rvalid is registered: o_x_rvalid <= o_x_gnt & ~i_x_we. It is a 1-cycle pulse per read.
  - o_x_rdata = {i_b_dout_h, i_b_dout_l} when the owner register equals x, else 0.
  - The owner register is loaded with the granted requester on any read grant.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on an edge with i_l_req=1 and o_c_gnt=1.
  - Clears on o_l_gnt=1 or i_l_req=0.
  - Not updated in LOCK.
- Back-to-back accesses from either side: one per cycle, no bubbles.
- Pipelined reads: a read granted in cycle N has rvalid in N+1 even if a different requester is granted in N+1; rdata ownership follows the grant that produced it.
- Ungranted requesters must hold their request and fields until granted. The arbiter does not queue.

Test Plan:
- CPU read at addr 0x005 (mem=0xA55A), no loader -> o_c_gnt=1 same cycle; o_c_rvalid=1 next cycle with o_c_rdata=0xA55A; o_l_rvalid=0.
- Both requesting every cycle, STARVE_MAX=4 -> grant pattern C,C,C,C,L repeating; counter returns to 0 after each loader grant.
- CPU write be=10, wdata=0x1234 to addr 3 (old 0xFFFF) -> o_b_we_h=1, o_b_we_l=0; subsequent read returns 0x12FF.
- Loader req+lock at cycle 0, then 6 loader writes while CPU requests -> o_lock=1 from cycle 1; o_c_gnt=0 throughout; CPU granted in the cycle after the i_l_lock=0 cycle.
- CPU read granted cycle N, loader read granted N+1 -> o_c_rvalid at N+1 with CPU data; o_l_rvalid at N+2 with loader data; never both rvalid in one cycle.
- Assert i_rst_n=0 mid-LOCK with a read in flight -> immediately o_lock=0, all rvalid=0, no grants; after release, CPU wins the first contended cycle.
